// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch pipeline: state encoding and drain default.
// INSTRW and HALT_INSTR normally come from the project-wide defines; the guarded
// fallbacks below only apply when those defines have not been seen yet.
`ifndef INSTRW
`define INSTRW 32
`endif
`ifndef HALT_INSTR
`define HALT_INSTR 32'hFC00_0000
`endif

package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  // Matches the data-fetch halt delay so done lines up with halt_ex.
  localparam int DRAIN_CYC_DEF = 3;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch stage: streams one instruction per cycle from a
// synchronous-read instruction memory to data fetch, stops on halt_if or at the
// end of memory, then drains for the halt's flight time before signalling done.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int IM_AW     = 10,
  parameter int DRAIN_CYC = DRAIN_CYC_DEF,
  parameter int CNT_W     = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [IM_AW-1:0]    pc_base,
  input  logic                pause,
  output logic                ren_im,
  output logic [IM_AW-1:0]    raddr_im,
  input  logic [`INSTRW-1:0]  instr_im,
  output logic                ins_valid,
  output logic [`INSTRW-1:0]  instr,
  input  logic                halt_if,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [CNT_W-1:0]    icount
);

  localparam int DCW = $clog2(DRAIN_CYC + 1);
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_CYC - 1);

  fetch_state_e     state_q;
  logic [IM_AW-1:0] pc_q, pc_d;
  logic             last_q, last_d;
  logic             err_q;
  logic             ins_valid_q;
  logic [CNT_W-1:0] icount_q, icount_d;
  logic [DCW-1:0]   drain_q;
  logic             drain_end;
  logic             run_end;

  // Read issue, next pc/last and saturating count. halt_if only gates the
  // read enable; instr_im depends on the registered address, so no loop forms.
  always_comb begin
    ren_im   = (state_q == RUN) && !pause && !halt_if && !last_q;
    pc_d     = pc_q;
    last_d   = last_q;
    if (ren_im) begin
      if (pc_q == '1) begin
        last_d = 1'b1;
      end else begin
        pc_d = pc_q + IM_AW'(1);
      end
    end
    icount_d = icount_q;
    if (ins_valid_q && (icount_q != '1)) begin
      icount_d = icount_q + CNT_W'(1);
    end
    drain_end = (state_q == DRAIN) && (drain_q == DRAIN_LAST);
    run_end   = (state_q == RUN) && (halt_if || (ins_valid_q && last_q));
  end

  // Control FSM plus all fetch state; reset overrides every other event.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      last_q      <= 1'b0;
      err_q       <= 1'b0;
      ins_valid_q <= 1'b0;
      icount_q    <= '0;
      drain_q     <= '0;
    end else begin
      ins_valid_q <= ren_im;
      icount_q    <= icount_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q  <= RUN;
            pc_q     <= pc_base;
            last_q   <= 1'b0;
            err_q    <= 1'b0;
            icount_q <= '0;
          end
        end
        RUN: begin
          pc_q   <= pc_d;
          last_q <= last_d;
          if (run_end) begin
            state_q <= DRAIN;
            drain_q <= '0;
            if (!halt_if) begin
              err_q <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (drain_end) begin
            state_q <= IDLE;
          end else begin
            drain_q <= drain_q + DCW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign raddr_im  = pc_q;
  assign ins_valid = ins_valid_q;
  assign instr     = ins_valid_q ? instr_im : '0;
  assign busy      = (state_q != IDLE);
  assign done      = drain_end;
  assign err       = err_q;
  assign icount    = icount_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: a synchronous instruction memory, halt decode from the
// presented instruction, and a reference model that derives the whole cycle
// trace from the fetched address range and the pause pattern.
`ifndef INSTRW
`define INSTRW 32
`endif
`ifndef HALT_INSTR
`define HALT_INSTR 32'hFC00_0000
`endif

module tb_instr_fetch;

  localparam int IM_AW = 10;
  localparam int DEPTH = 1 << IM_AW;
  localparam int DRAIN = 3;
  localparam int CNT_W = 32;
  localparam int MAXC  = 128;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [IM_AW-1:0]   pc_base;
  logic               pause;
  logic               ren_im;
  logic [IM_AW-1:0]   raddr_im;
  logic [`INSTRW-1:0] instr_im;
  logic               ins_valid;
  logic [`INSTRW-1:0] instr;
  logic               halt_if;
  logic               busy;
  logic               done;
  logic               err;
  logic [CNT_W-1:0]   icount;

  logic [`INSTRW-1:0] mem [DEPTH];
  bit                 pauseAt [MAXC];
  bit                 startAt [MAXC];
  logic [CNT_W-1:0]   prevCount;
  bit                 prevErr;
  int                 vectors = 0;
  int                 miscompares = 0;

  instr_fetch #(.IM_AW(IM_AW), .DRAIN_CYC(DRAIN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .pc_base(pc_base), .pause(pause),
    .ren_im(ren_im), .raddr_im(raddr_im), .instr_im(instr_im),
    .ins_valid(ins_valid), .instr(instr), .halt_if(halt_if),
    .busy(busy), .done(done), .err(err), .icount(icount)
  );

  always #5 clk = ~clk;

  // Synchronous-read instruction memory.
  always @(posedge clk) begin
    if (ren_im) instr_im <= mem[raddr_im];
  end

  assign halt_if = ins_valid && (instr == `HALT_INSTR);

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit st, input logic [IM_AW-1:0] pb, input bit pz, input bit rs);
    start   = st;
    pc_base = pb;
    pause   = pz;
    rst     = rs;
  endtask

  task automatic fillMem();
    logic [`INSTRW-1:0] v;
    for (int a = 0; a < DEPTH; a++) begin
      v = $urandom;
      if (v == `HALT_INSTR) v = v ^ 1;
      mem[a] = v;
    end
  endtask

  task automatic clearStim();
    for (int c = 0; c < MAXC; c++) begin
      pauseAt[c] = 1'b0;
      startAt[c] = 1'b0;
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " ren"}, 64'(ren_im), 64'd0);
    checkOutput({tag, " raddr"}, 64'(raddr_im), 64'd0);
    checkOutput({tag, " valid"}, 64'(ins_valid), 64'd0);
    checkOutput({tag, " instr"}, 64'(instr), 64'd0);
    checkOutput({tag, " busy"}, 64'(busy), 64'd0);
    checkOutput({tag, " done"}, 64'(done), 64'd0);
    checkOutput({tag, " err"}, 64'(err), 64'd0);
    checkOutput({tag, " icount"}, 64'(icount), 64'd0);
  endtask

  // Model: fetches run base, base+1, ... up to the first halt word or the last
  // address; the k-th fetch is read on the k-th unpaused cycle from cycle 1 and
  // shows up one cycle later; done follows the final fetch by DRAIN cycles.
  // Entered and left at #1 after a rising edge; start is driven in cycle 0.
  task automatic runScenario(input string tag, input int base, input int rstCyc);
    int n;
    bit halted;
    int readCyc[$];
    int lastValid, doneCyc, c, kr, kv, validSoFar;
    logic [`INSTRW-1:0] expInstr;
    string t;
    n = 0;
    halted = 1'b0;
    for (int a = base; a < DEPTH; a++) begin
      n++;
      if (mem[a] == `HALT_INSTR) begin
        halted = 1'b1;
        break;
      end
    end
    c = 1;
    while (readCyc.size() < n) begin
      if (!pauseAt[c]) readCyc.push_back(c);
      c++;
    end
    lastValid  = readCyc[n-1] + 1;
    doneCyc    = lastValid + DRAIN;
    validSoFar = 0;
    for (int cy = 0; cy <= doneCyc + 2; cy++) begin
      applyStimulus((cy == 0) || (startAt[cy] && cy <= doneCyc),
                    (cy == 0) ? IM_AW'(base) : IM_AW'($urandom),
                    pauseAt[cy], cy == rstCyc);
      @(negedge clk);
      t = $sformatf("%s c%0d", tag, cy);
      if (rstCyc >= 0 && cy == rstCyc + 1) begin
        checkAllZero({t, " after-rst"});
        prevCount = '0;
        prevErr   = 1'b0;
        @(posedge clk);
        #1;
        return;
      end
      kr = -1;
      kv = -1;
      foreach (readCyc[i]) begin
        if (readCyc[i] == cy) kr = i;
        if (readCyc[i] + 1 == cy) kv = i;
      end
      checkOutput({t, " ren"}, 64'(ren_im), 64'(kr >= 0));
      if (kr >= 0) checkOutput({t, " raddr"}, 64'(raddr_im), 64'(base + kr));
      expInstr = (kv >= 0) ? mem[base + kv] : '0;
      checkOutput({t, " valid"}, 64'(ins_valid), 64'(kv >= 0));
      checkOutput({t, " instr"}, 64'(instr), 64'(expInstr));
      checkOutput({t, " done"}, 64'(done), 64'(cy == doneCyc));
      checkOutput({t, " busy"}, 64'(busy), 64'(cy >= 1 && cy <= doneCyc));
      checkOutput({t, " icount"}, 64'(icount), (cy == 0) ? 64'(prevCount) : 64'(validSoFar));
      checkOutput({t, " err"}, 64'(err), (cy == 0) ? 64'(prevErr) : 64'(!halted && cy > lastValid));
      if (kv >= 0) validSoFar++;
      @(posedge clk);
      #1;
    end
    prevCount = CNT_W'(n);
    prevErr   = !halted;
  endtask

  initial begin
    int base, hp;
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    clearStim();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkAllZero("reset");
    prevCount = '0;
    prevErr   = 1'b0;
    @(posedge clk);
    #1;

    // Basic run: four instructions then a halt at 0x014.
    fillMem();
    mem[20] = `HALT_INSTR;
    runScenario("basic", 16, -1);

    // Pause over cycles 3-5 of the same program.
    for (int c = 3; c <= 5; c++) pauseAt[c] = 1'b1;
    runScenario("pause", 16, -1);
    clearStim();

    // Run off the end of memory with no halt.
    fillMem();
    runScenario("eom", DEPTH - 2, -1);

    // Halt as the very first instruction.
    fillMem();
    mem[64] = `HALT_INSTR;
    runScenario("imm", 64, -1);

    // Reset in cycle 4, then a clean relaunch.
    fillMem();
    mem[20] = `HALT_INSTR;
    runScenario("rstmid", 16, 4);
    runScenario("restart", 16, -1);

    // start pulses on every busy cycle, including the done cycle.
    for (int c = 1; c < MAXC; c++) startAt[c] = 1'b1;
    runScenario("startbusy", 16, -1);
    clearStim();

    // Randomized programs, bases, pause and stray start patterns.
    for (int r = 0; r < 20; r++) begin
      fillMem();
      base = $urandom_range(0, DEPTH - 1);
      if ($urandom_range(0, 3) == 0) begin
        base = DEPTH - $urandom_range(1, 4);
      end else begin
        hp = base + $urandom_range(0, 8);
        if (hp < DEPTH) mem[hp] = `HALT_INSTR;
      end
      for (int c = 0; c < MAXC; c++) begin
        pauseAt[c] = (c >= 1 && c < 60) ? ($urandom_range(0, 3) == 0) : 1'b0;
        startAt[c] = ($urandom_range(0, 5) == 0);
      end
      runScenario($sformatf("rand%0d", r), base, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
